// File: rtl/riscv_pkg.sv
// Shared types for the pipelined RV32I core.
//   alu_op_t  : ALU operation encodings (ADD..AND)
//   opa_sel_e : ALU operand A source (rs1 / PC)
//   opb_sel_e : ALU operand B source (rs2 / immediate)
//   reg_idx_t : architectural register index
//   id_ex_t   : fields held by the ID/EX pipeline register
package riscv_pkg;

    localparam int unsigned RV_XLEN   = 32;
    localparam int unsigned RV_RIDX_W = 5;

    typedef logic [RV_RIDX_W-1:0] reg_idx_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

    typedef enum logic {
        OPA_RS1 = 1'b0,
        OPA_PC  = 1'b1
    } opa_sel_e;

    typedef enum logic {
        OPB_RS2 = 1'b0,
        OPB_IMM = 1'b1
    } opb_sel_e;

    typedef struct packed {
        logic [RV_XLEN-1:0] pc;
        reg_idx_t           rs1;
        reg_idx_t           rs2;
        logic [RV_XLEN-1:0] rs1_data;
        logic [RV_XLEN-1:0] rs2_data;
        logic [RV_XLEN-1:0] imm;
        opa_sel_e           opa_sel;
        opb_sel_e           opb_sel;
        alu_op_t            op;
        reg_idx_t           rd;
        logic               rd_we;
    } id_ex_t;

    // A producer feeds a source only when it writes a nonzero register of the same index.
    function automatic logic rs_match(input logic we, input reg_idx_t rd, input reg_idx_t rs);
        return we && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/operand_fwd.sv
// Resolves one ALU source register value.
//   rs_i       : source register index of the held entry
//   stored_i   : register data stored with the held entry
//   exm_*      : EX/MEM producer (rd / write enable / data)
//   mwb_*      : MEM/WB producer (rd / write enable / data)
//   data_o     : resolved source value
// Build option: ID_EX_FWD_EN enables EX/MEM and MEM/WB forwarding (EX/MEM has
// priority). Without it the stored value passes through unchanged.
module operand_fwd #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned RIDX_W = 5
) (
    input  logic [RIDX_W-1:0] rs_i,
    input  logic [XLEN-1:0]   stored_i,
    input  logic [RIDX_W-1:0] exm_rd_i,
    input  logic              exm_we_i,
    input  logic [XLEN-1:0]   exm_data_i,
    input  logic [RIDX_W-1:0] mwb_rd_i,
    input  logic              mwb_we_i,
    input  logic [XLEN-1:0]   mwb_data_i,
    output logic [XLEN-1:0]   data_o
);

`ifdef ID_EX_FWD_EN
    logic exm_hit;
    logic mwb_hit;

    assign exm_hit = exm_we_i && (exm_rd_i != '0) && (exm_rd_i == rs_i);
    assign mwb_hit = mwb_we_i && (mwb_rd_i != '0) && (mwb_rd_i == rs_i);

    always_comb begin
        data_o = stored_i;
        if (exm_hit) begin
            data_o = exm_data_i;
        end else if (mwb_hit) begin
            data_o = mwb_data_i;
        end
    end
`else
    logic unused_fwd;

    assign unused_fwd = ^{rs_i, exm_rd_i, exm_we_i, exm_data_i, mwb_rd_i, mwb_we_i, mwb_data_i};
    assign data_o     = stored_i;
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the pipelined RV32I core.
//   clk_i, rst_ni (sync, active-low), flush_i
//   id_*      : decoded instruction in (valid/ready handshake)
//   exm_*     : EX/MEM producer; mwb_* : MEM/WB producer (also regfile write)
//   ex_valid_o / ex_ready_i : handshake toward the ALU
//   opr_a_o, opr_b_o, op_sel_o : resolved ALU operands and operation
//   rd_o, rd_we_o, pc_o       : destination and PC of the held entry
// Build option: ID_EX_FWD_EN enables operand forwarding. Without it, a
// read-after-write hazard against the held entry or EX/MEM deasserts id_ready_o.
// XLEN/RIDX_W must match the riscv_pkg widths (held fields use id_ex_t).
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned RIDX_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              id_valid_i,
    output logic              id_ready_o,
    input  logic [XLEN-1:0]   id_pc_i,
    input  logic [RIDX_W-1:0] id_rs1_i,
    input  logic [RIDX_W-1:0] id_rs2_i,
    input  logic [XLEN-1:0]   id_rs1_data_i,
    input  logic [XLEN-1:0]   id_rs2_data_i,
    input  logic [XLEN-1:0]   id_imm_i,
    input  logic              id_opa_sel_i,
    input  logic              id_opb_sel_i,
    input  logic [3:0]        id_op_sel_i,
    input  logic [RIDX_W-1:0] id_rd_i,
    input  logic              id_rd_we_i,
    input  logic [RIDX_W-1:0] exm_rd_i,
    input  logic              exm_we_i,
    input  logic [XLEN-1:0]   exm_data_i,
    input  logic [RIDX_W-1:0] mwb_rd_i,
    input  logic              mwb_we_i,
    input  logic [XLEN-1:0]   mwb_data_i,
    output logic              ex_valid_o,
    input  logic              ex_ready_i,
    output logic [XLEN-1:0]   opr_a_o,
    output logic [XLEN-1:0]   opr_b_o,
    output logic [3:0]        op_sel_o,
    output logic [RIDX_W-1:0] rd_o,
    output logic              rd_we_o,
    output logic [XLEN-1:0]   pc_o
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } vstate_e;

    vstate_e         state_q, state_d;
    id_ex_t          held_q, held_d;
    logic            capture;
    logic            interlock;
    logic [XLEN-1:0] fwd_rs1, fwd_rs2;

    assign ex_valid_o = (state_q == FULL);

`ifdef ID_EX_FWD_EN
    assign interlock = 1'b0;
`else
    // MEM/WB is not checked: the capture-time bypass already covers it.
    logic hit_rs1, hit_rs2;

    assign hit_rs1 = rs_match(ex_valid_o & held_q.rd_we, held_q.rd, id_rs1_i)
                   | rs_match(exm_we_i, exm_rd_i, id_rs1_i);
    assign hit_rs2 = rs_match(ex_valid_o & held_q.rd_we, held_q.rd, id_rs2_i)
                   | rs_match(exm_we_i, exm_rd_i, id_rs2_i);
    assign interlock = id_valid_i & (((id_opa_sel_i == OPA_RS1) & hit_rs1)
                                   | ((id_opb_sel_i == OPB_RS2) & hit_rs2));
`endif

    assign id_ready_o = rst_ni & (~ex_valid_o | ex_ready_i) & ~interlock;
    assign capture    = id_valid_i & id_ready_o & ~flush_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else if (capture) begin
            state_d = FULL;
        end else if (ex_valid_o && ex_ready_i) begin
            state_d = EMPTY;
        end
    end

    always_comb begin
        held_d = held_q;
        if (capture) begin
            held_d.pc       = id_pc_i;
            held_d.rs1      = id_rs1_i;
            held_d.rs2      = id_rs2_i;
            held_d.imm      = id_imm_i;
            held_d.opa_sel  = opa_sel_e'(id_opa_sel_i);
            held_d.opb_sel  = opb_sel_e'(id_opb_sel_i);
            held_d.op       = alu_op_t'(id_op_sel_i);
            held_d.rd       = id_rd_i;
            held_d.rd_we    = id_rd_we_i;
            held_d.rs1_data = (id_rs1_i == '0) ? '0 :
                              rs_match(mwb_we_i, mwb_rd_i, id_rs1_i) ? mwb_data_i : id_rs1_data_i;
            held_d.rs2_data = (id_rs2_i == '0) ? '0 :
                              rs_match(mwb_we_i, mwb_rd_i, id_rs2_i) ? mwb_data_i : id_rs2_data_i;
        end else if (ex_valid_o) begin
            // The regfile write lands while we hold; keep its value so it survives WB retiring.
            if (rs_match(mwb_we_i, mwb_rd_i, held_q.rs1)) begin
                held_d.rs1_data = mwb_data_i;
            end
            if (rs_match(mwb_we_i, mwb_rd_i, held_q.rs2)) begin
                held_d.rs2_data = mwb_data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            held_q    <= '0;
            held_q.op <= ALU_ADD;
        end else begin
            held_q <= held_d;
        end
    end

    operand_fwd #(.XLEN(XLEN), .RIDX_W(RIDX_W)) u_fwd_rs1 (
        .rs_i       (held_q.rs1),
        .stored_i   (held_q.rs1_data),
        .exm_rd_i   (exm_rd_i),
        .exm_we_i   (exm_we_i),
        .exm_data_i (exm_data_i),
        .mwb_rd_i   (mwb_rd_i),
        .mwb_we_i   (mwb_we_i),
        .mwb_data_i (mwb_data_i),
        .data_o     (fwd_rs1)
    );

    operand_fwd #(.XLEN(XLEN), .RIDX_W(RIDX_W)) u_fwd_rs2 (
        .rs_i       (held_q.rs2),
        .stored_i   (held_q.rs2_data),
        .exm_rd_i   (exm_rd_i),
        .exm_we_i   (exm_we_i),
        .exm_data_i (exm_data_i),
        .mwb_rd_i   (mwb_rd_i),
        .mwb_we_i   (mwb_we_i),
        .mwb_data_i (mwb_data_i),
        .data_o     (fwd_rs2)
    );

    assign opr_a_o  = (held_q.opa_sel == OPA_PC)  ? held_q.pc  : fwd_rs1;
    assign opr_b_o  = (held_q.opb_sel == OPB_IMM) ? held_q.imm : fwd_rs2;
    assign op_sel_o = held_q.op;
    assign rd_o     = held_q.rd;
    assign rd_we_o  = ex_valid_o & held_q.rd_we;
    assign pc_o     = held_q.pc;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage (default and ID_EX_FWD_EN builds).
module tb_id_ex_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni, flush_i, id_valid_i, id_ready_o;
    logic [31:0] id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
    logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
    logic        id_opa_sel_i, id_opb_sel_i, id_rd_we_i;
    logic [3:0]  id_op_sel_i;
    logic [4:0]  exm_rd_i, mwb_rd_i;
    logic        exm_we_i, mwb_we_i;
    logic [31:0] exm_data_i, mwb_data_i;
    logic        ex_valid_o, ex_ready_i, rd_we_o;
    logic [31:0] opr_a_o, opr_b_o, pc_o;
    logic [3:0]  op_sel_o;
    logic [4:0]  rd_o;

    int unsigned total  = 0;
    int unsigned passed = 0;

    always #5 clk_i = ~clk_i;

    id_ex_stage #(.XLEN(32), .RIDX_W(5)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .id_ready_o(id_ready_o), .id_pc_i(id_pc_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
        .id_imm_i(id_imm_i), .id_opa_sel_i(id_opa_sel_i), .id_opb_sel_i(id_opb_sel_i),
        .id_op_sel_i(id_op_sel_i), .id_rd_i(id_rd_i), .id_rd_we_i(id_rd_we_i),
        .exm_rd_i(exm_rd_i), .exm_we_i(exm_we_i), .exm_data_i(exm_data_i),
        .mwb_rd_i(mwb_rd_i), .mwb_we_i(mwb_we_i), .mwb_data_i(mwb_data_i),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
        .opr_a_o(opr_a_o), .opr_b_o(opr_b_o), .op_sel_o(op_sel_o),
        .rd_o(rd_o), .rd_we_o(rd_we_o), .pc_o(pc_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_id(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] d1,
                          input logic [4:0] rs2, input logic [31:0] d2, input logic [31:0] imm,
                          input logic opa, input logic opb, input logic [3:0] op,
                          input logic [4:0] rd, input logic we);
        id_pc_i = pc; id_rs1_i = rs1; id_rs1_data_i = d1; id_rs2_i = rs2; id_rs2_data_i = d2;
        id_imm_i = imm; id_opa_sel_i = opa; id_opb_sel_i = opb; id_op_sel_i = op;
        id_rd_i = rd; id_rd_we_i = we;
    endtask

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; id_valid_i = 1'b1; ex_ready_i = 1'b1;
        exm_rd_i = '0; exm_we_i = 1'b0; exm_data_i = '0;
        mwb_rd_i = '0; mwb_we_i = 1'b0; mwb_data_i = '0;
        set_id(32'h100, 5'd1, 32'd5, 5'd2, 32'd7, 32'h0, 1'b0, 1'b0, 4'd0, 5'd3, 1'b1);

        // Reset with a valid instruction presented
        tick(); tick();
        check("rst_ex_valid", {31'd0, ex_valid_o}, 32'd0);
        check("rst_id_ready", {31'd0, id_ready_o}, 32'd0);
        check("rst_op_sel",   {28'd0, op_sel_o},   32'd0);
        check("rst_rd_we",    {31'd0, rd_we_o},    32'd0);
        check("rst_opr_a",    opr_a_o,             32'd0);
        rst_ni = 1'b1;
        #1;
        check("empty_id_ready", {31'd0, id_ready_o}, 32'd1);

        // Back-to-back stream, ADD x1(5), x2(7)
        for (int i = 0; i < 4; i++) begin
            set_id(32'h100 + 32'(4 * i), 5'd1, 32'd5, 5'd2, 32'd7, 32'h0, 1'b0, 1'b0, 4'd0, 5'd3, 1'b1);
            tick();
            check("stream_valid", {31'd0, ex_valid_o}, 32'd1);
            check("stream_opr_a", opr_a_o, 32'd5);
            check("stream_opr_b", opr_b_o, 32'd7);
            check("stream_pc",    pc_o,    32'h100 + 32'(4 * i));
        end
        check("stream_rd",    {27'd0, rd_o},    32'd3);
        check("stream_rd_we", {31'd0, rd_we_o}, 32'd1);

        // Stall with new instruction waiting; WB writes x1=9 during hold
        ex_ready_i = 1'b0;
        set_id(32'h200, 5'd5, 32'h55, 5'd6, 32'h66, 32'h0, 1'b0, 1'b0, 4'd1, 5'd7, 1'b1);
        mwb_we_i = 1'b1; mwb_rd_i = 5'd1; mwb_data_i = 32'd9;
        #1;
        check("stall_id_ready", {31'd0, id_ready_o}, 32'd0);
        tick();
        check("stall_refresh_a", opr_a_o, 32'd9);
        check("stall_pc",        pc_o,    32'h10C);
        mwb_we_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stall_hold_a",  opr_a_o,  32'd9);
            check("stall_hold_b",  opr_b_o,  32'd7);
            check("stall_hold_pc", pc_o,     32'h10C);
            check("stall_hold_op", {28'd0, op_sel_o}, 32'd0);
            check("stall_valid",   {31'd0, ex_valid_o}, 32'd1);
        end

        // Flush coinciding with a capture
        ex_ready_i = 1'b1; flush_i = 1'b1;
        tick();
        check("flush_valid", {31'd0, ex_valid_o}, 32'd0);
        check("flush_rd_we", {31'd0, rd_we_o},    32'd0);
        flush_i = 1'b0; id_valid_i = 1'b0;
        tick();
        check("flush_after_valid", {31'd0, ex_valid_o}, 32'd0);

        // WB bypass at capture, x0 source forced to zero
        id_valid_i = 1'b1;
        set_id(32'h300, 5'd7, 32'h11, 5'd0, 32'h1234, 32'h0, 1'b0, 1'b0, 4'd1, 5'd5, 1'b1);
        mwb_we_i = 1'b1; mwb_rd_i = 5'd7; mwb_data_i = 32'h77;
        tick();
        check("byp_opr_a",  opr_a_o, 32'h77);
        check("byp_x0_b",   opr_b_o, 32'd0);
        check("byp_op_sel", {28'd0, op_sel_o}, 32'd1);
        check("byp_rd",     {27'd0, rd_o},     32'd5);
        mwb_we_i = 1'b0;
        set_id(32'h304, 5'd7, 32'h11, 5'd2, 32'h22, 32'hFFFF_FFF0, 1'b1, 1'b1, 4'd0, 5'd6, 1'b1);
        tick();
        check("pc_imm_a", opr_a_o, 32'h304);
        check("pc_imm_b", opr_b_o, 32'hFFFF_FFF0);
        id_valid_i = 1'b0;
        tick();
        check("retire_valid", {31'd0, ex_valid_o}, 32'd0);

`ifdef ID_EX_FWD_EN
        // Forwarding priority and x0 exclusion
        id_valid_i = 1'b1;
        set_id(32'h400, 5'd3, 32'd1, 5'd0, 32'd0, 32'h0, 1'b0, 1'b1, 4'd0, 5'd8, 1'b1);
        tick();
        id_valid_i = 1'b0; ex_ready_i = 1'b0;
        exm_we_i = 1'b1; exm_rd_i = 5'd3; exm_data_i = 32'hAA;
        mwb_we_i = 1'b1; mwb_rd_i = 5'd3; mwb_data_i = 32'hBB;
        #1;
        check("fwd_exm_a", opr_a_o, 32'hAA);
        exm_we_i = 1'b0;
        #1;
        check("fwd_mwb_a", opr_a_o, 32'hBB);
        mwb_we_i = 1'b0;
        #1;
        check("fwd_none_a", opr_a_o, 32'd1);
        ex_ready_i = 1'b1; id_valid_i = 1'b1;
        set_id(32'h404, 5'd0, 32'h55, 5'd0, 32'd0, 32'h0, 1'b0, 1'b1, 4'd0, 5'd8, 1'b1);
        tick();
        id_valid_i = 1'b0; ex_ready_i = 1'b0;
        exm_we_i = 1'b1; exm_rd_i = 5'd0; exm_data_i = 32'hFF;
        #1;
        check("fwd_x0_a", opr_a_o, 32'd0);
        exm_we_i = 1'b0;
`else
        // Interlock against held entry and EX/MEM; MEM/WB handled by bypass
        id_valid_i = 1'b1;
        set_id(32'h500, 5'd9, 32'h9, 5'd10, 32'h0, 32'h0, 1'b0, 1'b1, 4'd0, 5'd4, 1'b1);
        tick();
        ex_ready_i = 1'b0;
        set_id(32'h504, 5'd9, 32'h9, 5'd4, 32'h40, 32'h0, 1'b0, 1'b0, 4'd0, 5'd4, 1'b1);
        #1;
        check("ilk_stalled_ready", {31'd0, id_ready_o}, 32'd0);
        ex_ready_i = 1'b1;
        #1;
        check("ilk_held_ready", {31'd0, id_ready_o}, 32'd0);
        tick();
        exm_we_i = 1'b1; exm_rd_i = 5'd4; exm_data_i = 32'h44;
        #1;
        check("ilk_retired_valid", {31'd0, ex_valid_o}, 32'd0);
        check("ilk_exm_ready",     {31'd0, id_ready_o}, 32'd0);
        tick();
        check("ilk_exm_hold_valid", {31'd0, ex_valid_o}, 32'd0);
        exm_we_i = 1'b0; mwb_we_i = 1'b1; mwb_rd_i = 5'd4; mwb_data_i = 32'h44;
        #1;
        check("ilk_mwb_ready", {31'd0, id_ready_o}, 32'd1);
        tick();
        mwb_we_i = 1'b0;
        check("ilk_cap_valid", {31'd0, ex_valid_o}, 32'd1);
        check("ilk_cap_b",     opr_b_o, 32'h44);
        check("ilk_cap_pc",    pc_o,    32'h504);
        set_id(32'h508, 5'd9, 32'h9, 5'd4, 32'h0, 32'h8, 1'b0, 1'b1, 4'd0, 5'd6, 1'b1);
        #1;
        check("ilk_imm_ready", {31'd0, id_ready_o}, 32'd1);
        id_opb_sel_i = 1'b0;
        #1;
        check("ilk_rs2_ready", {31'd0, id_ready_o}, 32'd0);
        id_opb_sel_i = 1'b1;
        tick();
        check("ilk_imm_pc", pc_o,    32'h508);
        check("ilk_imm_b",  opr_b_o, 32'h8);
        id_valid_i = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
